ifq_multi: RTL

- Parametrised instruction fetch queue between the instruction cache and the dispatch unit.
- Fetches whole cache lines into a circular line buffer and delivers one instruction per cycle to dispatch.
- Supports multi-cycle icache latency: one outstanding request is tracked and aborted on redirect.
- Depth and line width are parameters.

---
 rtl/ifq_multi.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ifq_multi.sv
// ifq_multi: instruction fetch queue between the icache and dispatch.
// Whole cache lines are fetched into a circular buffer of N_ENTRY slots, and
// dispatch receives one instruction per cycle. At most one icache request is
// outstanding. A redirect aborts that request and refetches from the target.
// Optional feature: define IFQ_BYPASS_EN to forward a returning line straight
// to dispatch when the queue is empty.
module ifq_multi #(
  parameter int N_ENTRY       = 4,
  parameter int INST_PER_LINE = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [31:0]                   icache_pcin,
  output logic                          icache_ren,
  output logic                          icache_abort,
  input  logic [32*INST_PER_LINE-1:0]   icache_dout,
  input  logic                          icache_dout_valid,
  output logic [31:0]                   dispatch_pcout_plus4,
  output logic [31:0]                   dispatch_inst,
  output logic                          dispatch_empty,
  input  logic                          dispatch_ren,
  input  logic [31:0]                   dispatch_branch_addr,
  input  logic                          dispatch_branch_valid
);
  localparam int LINE_W = 32*INST_PER_LINE;
  localparam int OFF_W  = $clog2(INST_PER_LINE);
  localparam int SLOT_W = $clog2(N_ENTRY);
  localparam int PTR_W  = SLOT_W + OFF_W + 1;
  localparam logic [31:0] LINE_BYTES = 32'(4*INST_PER_LINE);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                         state_reg, state_next;
  logic [PTR_W-1:0]               rptr_reg, rptr_next, wptr_reg, wptr_next;
  logic [31:0]                    pcin_reg, pcin_next, head_pc_reg, head_pc_next;
  logic [N_ENTRY-1:0][LINE_W-1:0] mem_reg;

  logic [SLOT_W:0]   rd_line, wr_line, occ;
  logic [SLOT_W+1:0] committed;
  logic [SLOT_W-1:0] rd_slot, wr_slot;
  logic [OFF_W-1:0]  rd_off;
  logic [LINE_W-1:0] rd_line_data;
  logic [31:0]       mem_word [INST_PER_LINE];
  logic [31:0]       head_inst, branch_line, req_addr;
  logic              space, queue_empty, avail, bypass_hit, pop, req, abort, wr_en;
  logic              unused_addr_bits;

  // The two byte-offset bits of the redirect target carry no information.
  assign unused_addr_bits = &{1'b0, dispatch_branch_addr[1:0]};

  assign rd_line = rptr_reg[PTR_W-1:OFF_W];
  assign wr_line = wptr_reg[PTR_W-1:OFF_W];
  assign rd_slot = rptr_reg[PTR_W-2:OFF_W];
  assign wr_slot = wptr_reg[PTR_W-2:OFF_W];
  assign rd_off  = rptr_reg[OFF_W-1:0];

  // A request in flight already owns a slot, so a returned line always fits.
  assign occ       = wr_line - rd_line;
  assign committed = {1'b0, occ} + (SLOT_W+2)'(state_reg == WAIT);
  assign space     = committed < (SLOT_W+2)'(N_ENTRY);

  // The write pointer is always line aligned, so comparing line indices alone
  // also covers the post-redirect state where the read pointer sits at a
  // skipped-word offset of a line that has not arrived yet.
  assign queue_empty = (rd_line == wr_line);

  assign rd_line_data = mem_reg[rd_slot];
  assign branch_line  = {dispatch_branch_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};

  for (genvar gi = 0; gi < INST_PER_LINE; gi++) begin : g_word
    assign mem_word[gi] = rd_line_data[32*gi +: 32];
  end

`ifdef IFQ_BYPASS_EN
  logic [31:0] dout_word [INST_PER_LINE];
  for (genvar gi = 0; gi < INST_PER_LINE; gi++) begin : g_dout_word
    assign dout_word[gi] = icache_dout[32*gi +: 32];
  end
  assign bypass_hit = queue_empty && (state_reg == WAIT) && icache_dout_valid &&
                      !dispatch_branch_valid;
  assign head_inst  = bypass_hit ? dout_word[rd_off] : mem_word[rd_off];
`else
  assign bypass_hit = 1'b0;
  assign head_inst  = mem_word[rd_off];
`endif

  assign avail = !queue_empty || bypass_hit;
  assign pop   = dispatch_ren && avail && !dispatch_branch_valid;

  assign icache_ren           = req && !reset;
  assign icache_abort         = abort && !reset;
  assign icache_pcin          = req_addr;
  assign dispatch_empty       = reset || !avail;
  assign dispatch_inst        = head_inst;
  assign dispatch_pcout_plus4 = reset ? 32'd4 : head_pc_reg + 32'd4;

  // Next-state logic: redirect first, then fetch FSM, then dispatch pop.
  always_comb begin
    state_next   = state_reg;
    rptr_next    = rptr_reg;
    wptr_next    = wptr_reg;
    pcin_next    = pcin_reg;
    head_pc_next = head_pc_reg;
    req          = 1'b0;
    req_addr     = pcin_reg;
    abort        = 1'b0;
    wr_en        = 1'b0;
    if (dispatch_branch_valid) begin
      req          = 1'b1;
      req_addr     = branch_line;
      abort        = (state_reg == WAIT);
      pcin_next    = branch_line + LINE_BYTES;
      wptr_next    = '0;
      rptr_next    = {{(SLOT_W+1){1'b0}}, dispatch_branch_addr[OFF_W+1:2]};
      head_pc_next = {dispatch_branch_addr[31:2], 2'b00};
      state_next   = WAIT;
    end else begin
      case (state_reg)
        IDLE: begin
          if (space) begin
            req        = 1'b1;
            pcin_next  = pcin_reg + LINE_BYTES;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (icache_dout_valid) begin
            wr_en      = 1'b1;
            wptr_next  = wptr_reg + PTR_W'(INST_PER_LINE);
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
      if (pop) begin
        rptr_next    = rptr_reg + PTR_W'(1);
        head_pc_next = head_pc_reg + 32'd4;
      end
    end
  end

  // Pointer, address and FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      rptr_reg    <= '0;
      wptr_reg    <= '0;
      pcin_reg    <= '0;
      head_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rptr_reg    <= rptr_next;
      wptr_reg    <= wptr_next;
      pcin_reg    <= pcin_next;
      head_pc_reg <= head_pc_next;
    end
  end

  // Line buffer: cleared on reset, one whole line written per returned fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRY; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      mem_reg[wr_slot] <= icache_dout;
    end
  end
endmodule
